// File: rtl/spc700_ram_arbiter.sv
// spc700_ram_arbiter: shares the audio RAM port between the CPU and the DSP, DSP first with a CPU starvation bound.
// Define SPC700_RAM_ARB_STATS_EN to enable the saturating conflict-cycle counter on stat_conflicts.
module spc700_ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,
    input  logic        dsp_req,
    input  logic        dsp_we,
    input  logic [15:0] dsp_addr,
    input  logic [7:0]  dsp_wdata,
    output logic        dsp_gnt,
    output logic        dsp_rvalid,
    output logic [7:0]  dsp_rdata,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata,
    output logic [15:0] stat_conflicts
);
    typedef enum logic [1:0] {ARB_IDLE, ARB_CPU, ARB_DSP} arb_state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    arb_state_t state;
    logic [3:0] starve;
    logic [15:0] addr_q;
    logic [7:0] wdata_q;
    logic cpu_turn;
    assign cpu_turn = starve == LIMIT;
    assign cpu_gnt = reset_n & cpu_req & (~dsp_req | cpu_turn);
    assign dsp_gnt = reset_n & dsp_req & ~cpu_gnt;
    // Address is combinational so the synchronous RAM returns data exactly one cycle after the grant.
    assign ram_address = cpu_gnt ? cpu_addr : dsp_gnt ? dsp_addr : addr_q;
    assign ram_wdata = cpu_gnt ? cpu_wdata : dsp_gnt ? dsp_wdata : wdata_q;
    assign ram_we = (cpu_gnt & cpu_we) | (dsp_gnt & dsp_we);
    assign cpu_rvalid = state == ARB_CPU;
    assign dsp_rvalid = state == ARB_DSP;
    assign cpu_rdata = cpu_rvalid ? ram_rdata : '0;
    assign dsp_rdata = dsp_rvalid ? ram_rdata : '0;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
            starve <= '0;
            addr_q <= '0;
            wdata_q <= '0;
        end else begin
            state <= (cpu_gnt & ~cpu_we) ? ARB_CPU : (dsp_gnt & ~dsp_we) ? ARB_DSP : ARB_IDLE;
            starve <= (cpu_req & ~cpu_gnt) ? (cpu_turn ? starve : starve + 4'd1) : '0;
            addr_q <= ram_address;
            wdata_q <= ram_wdata;
        end
    end
`ifdef SPC700_RAM_ARB_STATS_EN
    logic [15:0] conflicts;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            conflicts <= '0;
        else if (cpu_req & dsp_req & ~&conflicts)
            conflicts <= conflicts + 16'd1;
    end
    assign stat_conflicts = conflicts;
`else
    assign stat_conflicts = '0;
`endif
endmodule

// File: tb/tb_spc700_ram_arbiter.sv
// tb_spc700_ram_arbiter: directed vector table, reset corner case and random traffic against a transaction-level model.
module tb_spc700_ram_arbiter;
    localparam int LIMIT = 4;
    logic clock = 0, reset_n = 0;
    logic cpu_req = 0, cpu_we = 0, dsp_req = 0, dsp_we = 0;
    logic [15:0] cpu_addr = 0, dsp_addr = 0;
    logic [7:0] cpu_wdata = 0, dsp_wdata = 0;
    logic cpu_gnt, cpu_rvalid, dsp_gnt, dsp_rvalid, ram_we;
    logic [7:0] cpu_rdata, dsp_rdata, ram_wdata;
    logic [7:0] ram_rdata = 0;
    logic [15:0] ram_address, stat_conflicts;

    spc700_ram_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dsp_req(dsp_req), .dsp_we(dsp_we), .dsp_addr(dsp_addr), .dsp_wdata(dsp_wdata),
        .dsp_gnt(dsp_gnt), .dsp_rvalid(dsp_rvalid), .dsp_rdata(dsp_rdata),
        .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .stat_conflicts(stat_conflicts)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [65536];
    always @(posedge clock) begin
        if (ram_we) mem[ram_address] <= ram_wdata;
        ram_rdata <= mem[ram_address];
    end

    // Model: shadow memory, denied-run length, and the one read still awaiting its data.
    logic [7:0] sh [65536];
    int starve_m, pend_m, confl_m;
    logic [7:0] pend_d, last_d;
    logic [15:0] last_a;
    int n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        starve_m = 0; pend_m = 0; confl_m = 0; last_a = 0; last_d = 0; pend_d = 0;
    endtask

    function automatic int exp_stat();
`ifdef SPC700_RAM_ARB_STATS_EN
        return confl_m;
`else
        return 0;
`endif
    endfunction

    task automatic cycle(input logic cr, input logic cw, input logic [15:0] ca, input logic [7:0] cd,
                         input logic dr, input logic dw, input logic [15:0] da, input logic [7:0] dd);
        logic eg_c, eg_d, ewe;
        logic [15:0] ea;
        logic [7:0] ed;
        @(negedge clock);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dsp_req = dr; dsp_we = dw; dsp_addr = da; dsp_wdata = dd;
        #1;
        eg_c = cr && (!dr || starve_m >= LIMIT);
        eg_d = dr && !eg_c;
        ea = eg_c ? ca : eg_d ? da : last_a;
        ed = eg_c ? cd : eg_d ? dd : last_d;
        ewe = (eg_c && cw) || (eg_d && dw);
        chk("cpu_gnt", cpu_gnt, eg_c);
        chk("dsp_gnt", dsp_gnt, eg_d);
        chk("ram_we", ram_we, ewe);
        chk("ram_address", ram_address, ea);
        chk("ram_wdata", ram_wdata, ed);
        chk("cpu_rvalid", cpu_rvalid, pend_m == 1);
        chk("dsp_rvalid", dsp_rvalid, pend_m == 2);
        if (pend_m == 1) chk("cpu_rdata", cpu_rdata, pend_d);
        if (pend_m == 2) chk("dsp_rdata", dsp_rdata, pend_d);
        chk("stat_conflicts", stat_conflicts, exp_stat());
        pend_m = ((eg_c || eg_d) && !ewe) ? (eg_c ? 1 : 2) : 0;
        if (pend_m != 0) pend_d = sh[ea];
        if (ewe) sh[ea] = ed;
        last_a = ea; last_d = ed;
        starve_m = (cr && !eg_c) ? ((starve_m + 1 > LIMIT) ? LIMIT : starve_m + 1) : 0;
        if (cr && dr && confl_m < 65535) confl_m++;
    endtask

    typedef struct {
        logic cr, cw; logic [15:0] ca; logic [7:0] cd;
        logic dr, dw; logic [15:0] da; logic [7:0] dd;
        logic ecg, edg, ewe, ecrv, edrv; logic [7:0] erd;
    } vec_t;
    vec_t tbl [19];

    function automatic vec_t mk(input logic cr, input logic cw, input logic [15:0] ca, input logic [7:0] cd,
                                input logic dr, input logic dw, input logic [15:0] da, input logic [7:0] dd,
                                input logic ecg, input logic edg, input logic ewe,
                                input logic ecrv, input logic edrv, input logic [7:0] erd);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.ecg = ecg; v.edg = edg; v.ewe = ewe; v.ecrv = ecrv; v.edrv = edrv; v.erd = erd;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) begin mem[i] = 8'h00; sh[i] = 8'h00; end
        mem[16'h1234] = 8'hA5; sh[16'h1234] = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            mem[16'h0100 + i] = 8'(i * 17 + 3); sh[16'h0100 + i] = 8'(i * 17 + 3);
        end
        model_reset();
        tbl[0] = mk(1,0,16'h1234,0, 0,0,0,0,       1,0,0, 0,0,8'h00);
        tbl[1] = mk(0,0,0,0,        0,0,0,0,       0,0,0, 1,0,8'hA5);
        tbl[2] = mk(0,0,0,0,        1,1,16'h0200,8'h3C, 0,1,1, 0,0,8'h00);
        tbl[3] = mk(1,0,16'h0200,0, 0,0,0,0,       1,0,0, 0,0,8'h00);
        tbl[4] = mk(0,0,0,0,        0,0,0,0,       0,0,0, 1,0,8'h3C);
        for (int i = 5; i < 15; i++)
            tbl[i] = mk(1,0,16'h1234,0, 1,0,16'h0200,0, i == 9 || i == 14, !(i == 9 || i == 14), 0,
                        i == 10, i >= 6 && i != 10, i == 10 ? 8'hA5 : 8'h3C);
        tbl[15] = mk(0,0,0,0,        0,0,0,0,          0,0,0, 1,0,8'hA5);
        tbl[16] = mk(0,0,0,0,        1,0,16'h0200,0,   0,1,0, 0,0,8'h00);
        tbl[17] = mk(1,0,16'h1234,0, 0,0,0,0,          1,0,0, 0,1,8'h3C);
        tbl[18] = mk(0,0,0,0,        0,0,0,0,          0,0,0, 1,0,8'hA5);

        repeat (2) @(posedge clock);
        @(negedge clock);
        cpu_req = 1; dsp_req = 1; cpu_we = 1; dsp_we = 1; cpu_addr = 16'hFFFF; dsp_addr = 16'hAAAA;
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dsp_gnt", dsp_gnt, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_rvalid", {cpu_rvalid, dsp_rvalid}, 0);
        chk("rst_ram_address", ram_address, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_stat", stat_conflicts, 0);
        @(negedge clock);
        cpu_req = 0; dsp_req = 0; cpu_we = 0; dsp_we = 0; cpu_addr = 0; dsp_addr = 0;
        reset_n = 1;

        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
            chk($sformatf("tbl%0d_gnt", i), {cpu_gnt, dsp_gnt, ram_we}, {tbl[i].ecg, tbl[i].edg, tbl[i].ewe});
            chk($sformatf("tbl%0d_rvalid", i), {cpu_rvalid, dsp_rvalid}, {tbl[i].ecrv, tbl[i].edrv});
            if (tbl[i].ecrv) chk($sformatf("tbl%0d_cpu_rdata", i), cpu_rdata, tbl[i].erd);
            if (tbl[i].edrv) chk($sformatf("tbl%0d_dsp_rdata", i), dsp_rdata, tbl[i].erd);
        end
`ifdef SPC700_RAM_ARB_STATS_EN
        chk("stat_after_10_conflicts", stat_conflicts, 10);
`else
        chk("stat_after_10_conflicts", stat_conflicts, 0);
`endif

        // Reset lands in the cycle where the granted read's data would have appeared.
        cycle(1,0,16'h1234,0, 0,0,0,0);
        @(posedge clock);
        #1;
        reset_n = 0;
        model_reset();
        #1;
        chk("midrd_rvalid", {cpu_rvalid, dsp_rvalid}, 0);
        chk("midrd_gnt", {cpu_gnt, dsp_gnt, ram_we}, 0);
        chk("midrd_ram_address", ram_address, 0);
        chk("midrd_stat", stat_conflicts, 0);
        @(posedge clock);
        @(negedge clock);
        cpu_req = 0; cpu_addr = 0;
        reset_n = 1;
        cycle(0,0,0,0, 0,0,0,0);
        cycle(1,0,16'h1234,0, 0,0,0,0);
        cycle(0,0,0,0, 0,0,0,0);

        // Back-to-back read then write to the same location must return the old byte.
        cycle(1,0,16'h0103,0, 0,0,0,0);
        cycle(0,0,0,0, 1,1,16'h0103,8'hEE);
        cycle(1,0,16'h0103,0, 0,0,0,0);
        cycle(0,0,0,0, 0,0,0,0);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0,1) == 1, $urandom_range(0,3) == 0, 16'h0100 + 16'($urandom_range(0,7)), 8'($urandom),
                  $urandom_range(0,1) == 1, $urandom_range(0,3) == 0, 16'h0100 + 16'($urandom_range(0,7)), 8'($urandom));
        cycle(0,0,0,0, 0,0,0,0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
